out_port: RTL
=============

# out_port

Output-port queue for the Nano processor. It accepts one byte per cycle while the control unit asserts `LdOUTPUT`, buffers the bytes in a small FIFO, and delivers them to an external consumer over a valid/ready handshake. It is the receiving end of the control unit's output command. The block also returns a `Full` status so firmware and control can throttle writes.

## Interface
Parameters:
- `WIDTH`, 8: data width; matches the ALU result width.
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`, in, 1: system clock; rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `LdOUTPUT`, in, 1: write strobe; one entry is written per cycle while it is high.
- `DadoOUT`, in, WIDTH: byte to enqueue; sampled when `LdOUTPUT` is high.
- `outData`, out, WIDTH: head-of-queue byte.
- `outValid`, out, 1: `outData` is valid.
- `outReady`, in, 1: consumer accepts the head this cycle.
- `Full`, out, 1: queue holds DEPTH entries.
- `Empty`, out, 1: queue holds 0 entries.
- `Count`, out, $clog2(DEPTH)+1: current occupancy.
- `Ovf`, out, 1: sticky overflow flag; present only with `OUTQ_OVF_EN`.
- `OvfCnt`, out, 8: count of dropped writes; present only with `OUTQ_OVF_EN`.

## Operation
- Storage: DEPTH×WIDTH register array.
  - Write pointer `wp` and read pointer `rp` are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - Occupancy `cnt` runs from 0 to DEPTH.
- Write acceptance: a write is accepted when `LdOUTPUT` is high and either `cnt` < DEPTH, or the queue is full and a pop happens in the same cycle.
  - On accept: `mem[wp]` <= `DadoOUT` and `wp` increments.
- Pop: a pop occurs when `outValid` && `outReady`; `rp` increments.
- Occupancy update:
  - Accepted write without pop: `cnt` +1.
  - Pop without write: `cnt` −1.
  - Both in the same cycle: `cnt` unchanged.
- Output flags and data:
  - `outValid` = (`cnt` != 0).
  - `outData` = `mem[rp]`. Its value is don't-care while `outValid` is 0; the bench must not check it then.
  - `Full` = (`cnt` == DEPTH); `Empty` = (`cnt` == 0); `Count` = `cnt`.
- Rejected write: a write while full with no pop is dropped. Queue contents and pointers stay unchanged.
- Consumer protocol: once `outValid` is high, `outData` stays stable until a pop.
- Queue states:
  - EMPTY: write → PARTIAL (or FULL when DEPTH reaches 1 entry short; not applicable since DEPTH ≥ 2).
  - PARTIAL: write only → FULL when `cnt` reaches DEPTH; pop only → EMPTY when `cnt` reaches 0; write + pop → stays PARTIAL.
  - FULL: pop → PARTIAL; write + pop → stays FULL; write only → stays FULL, write dropped.
- Reset:
  - Asserting `rst` low at any time, including mid-transfer, clears `wp`, `rp` and `cnt` to 0 and discards queued data.
  - After reset: `outValid` 0, `Full` 0, `Empty` 1, `Count` 0, `Ovf` 0, `OvfCnt` 0.
  - `mem` is not cleared.

## Timing
- Write-to-visible latency is 1 cycle. A byte written at edge N appears on `outData`/`outValid` after edge N; there is no same-cycle bypass from an empty queue.
- A pop at edge N exposes the next entry after edge N.
- Throughput is one write and one pop per cycle, sustained.
- `Full`, `Empty`, `Count` and `outValid` are decoded from registered state and contain no path from `LdOUTPUT` or `outReady`.
- Control-unit interaction: the control unit pulses `LdOUTPUT` for a single cycle per output instruction. A level held for k cycles writes k entries.

## Configuration
- Macro: `OUTQ_OVF_EN`.
- When defined:
  - A dropped write sets `Ovf` to 1; it stays set until reset.
  - `OvfCnt` increments on each dropped write and saturates at 255.
  - Both outputs are registered and update at the edge where the write is dropped.
- When undefined: the `Ovf` and `OvfCnt` ports and their logic are absent, and dropped writes are silent.

## Test plan
- Fill and drain: with DEPTH=4, write 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `outReady`=0 → `Full`=1, `Count`=4. Then hold `outReady`=1 → `outData` reads 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then `Empty`=1.
- Overflow: with the queue full, write 0x55 with `outReady`=0 → the write is dropped and `Count` stays 4. With `OUTQ_OVF_EN`: `Ovf`=1 and `OvfCnt`=1. Draining then yields 0x11 first, never 0x55.
- Simultaneous write and pop on a full queue: write 0x66 with `outReady`=1 → 0x11 is popped, 0x66 is accepted, `Full` stays 1, and 0x66 emerges fourth.
- Empty latency: on an empty queue, pulse `LdOUTPUT` with 0xA5 → `outValid` is 0 in that cycle and 1 with `outData`=0xA5 in the next. Pointer wrap: 10 write/pop pairs return the data in order.
- Stall stability: hold `outReady`=0 for 5 cycles with `outValid`=1 → `outData` is stable throughout. Then pop once → the next byte appears.
- Reset mid-operation: with `Count`=3, assert `rst` low asynchronously → all outputs take their reset values immediately. After release, the next write 0x0F becomes the head.

Source files
------------

// File: rtl/out_port.sv
// out_port: output-port queue for the Nano processor.
// Bytes strobed in by the control unit (LdOUTPUT/DadoOUT) are buffered in a
// DEPTH-entry FIFO and handed to an external consumer over a valid/ready
// handshake. Full/Empty/Count report occupancy so writers can throttle.
// Optional feature macro: OUTQ_OVF_EN adds a sticky overflow flag (Ovf) and a
// saturating dropped-write counter (OvfCnt).
module out_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       LdOUTPUT,
  input  logic [WIDTH-1:0]           DadoOUT,
  output logic [WIDTH-1:0]           outData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic                       Full,
  output logic                       Empty,
`ifdef OUTQ_OVF_EN
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Ovf,
  output logic [7:0]                 OvfCnt
`else
  output logic [$clog2(DEPTH):0]     Count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);

  // Coarse queue state, kept alongside the occupancy so the flags come
  // straight out of a register.
  typedef enum logic [1:0] {
    QEmpty   = 2'd0,
    QPartial = 2'd1,
    QFull    = 2'd2
  } queueState_e;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]  wrPtr_q, wrPtr_d;
  logic [AW-1:0]  rdPtr_q, rdPtr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  queueState_e    state_q, state_d;

  logic doPop;
  logic doWrite;
  logic doDrop;

  // Handshake decode: a pop needs a valid head, and a full queue can still
  // take a write when a pop frees a slot in the same cycle.
  always_comb begin
    doPop   = (cnt_q != '0) && outReady;
    doWrite = LdOUTPUT && ((cnt_q != CntFull) || doPop);
    doDrop  = LdOUTPUT && !doWrite;
  end

  // Next-state for pointers, occupancy and coarse queue state.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    state_d = state_q;

    if (doWrite) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end

    unique case ({doWrite, doPop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (cnt_d == '0) begin
      state_d = QEmpty;
    end else if (cnt_d == CntFull) begin
      state_d = QFull;
    end else begin
      state_d = QPartial;
    end
  end

  // Queue control registers; reset discards everything queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
      state_q <= QEmpty;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Storage array has no reset: stale bytes are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wrPtr_q] <= DadoOUT;
    end
  end

  // Status and head outputs, all decoded from registered state.
  always_comb begin
    outData  = mem[rdPtr_q];
    outValid = (state_q != QEmpty);
    Full     = (state_q == QFull);
    Empty    = (state_q == QEmpty);
    Count    = cnt_q;
  end

`ifdef OUTQ_OVF_EN
  logic       ovf_q;
  logic [7:0] ovfCnt_q;

  // Sticky overflow flag and saturating count of writes lost to a full queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q    <= 1'b0;
      ovfCnt_q <= 8'd0;
    end else if (doDrop) begin
      ovf_q <= 1'b1;
      if (ovfCnt_q != 8'hFF) begin
        ovfCnt_q <= ovfCnt_q + 8'd1;
      end
    end
  end

  assign Ovf    = ovf_q;
  assign OvfCnt = ovfCnt_q;
`else
  logic unusedDrop;
  assign unusedDrop = doDrop;
`endif

endmodule
